// File: rtl/debug_slave_monitor_access_pkg.sv
// Shared FSM state type and jdo field positions for the debug monitor RAM access block.
package debug_slave_monitor_access_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRdIssue = 2'd1,
        StRdWait  = 2'd2,
        StWr      = 2'd3
    } mon_state_e;

    localparam int unsigned MON_AW_DEFAULT = 8;

    localparam int unsigned JDO_RD_NOW    = 34;
    localparam int unsigned JDO_ERR_CLR   = 35;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/debug_slave_monitor_access.sv
// Sysclk-side executor of decoded JTAG monitor commands: reads and writes the on-chip
// debug monitor RAM with address auto-increment and reports data, ready and a sticky error.
module debug_slave_monitor_access
    import debug_slave_monitor_access_pkg::*;
#(
    parameter int unsigned MON_AW   = MON_AW_DEFAULT,
    parameter int unsigned ADDR_LSB = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    output logic [MON_AW-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [MON_AW-1:0] ADDR_ONE = MON_AW'(1);

    mon_state_e        state_q, state_d;
    logic [MON_AW-1:0] addr_q, addr_d;
    logic [31:0]       mon_q, mon_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic              inc_q, inc_d;

    logic              any_strobe;
    logic              err_set;
    logic              err_clr;
    logic              unused_jdo;

    // Not every jdo bit carries a field this block consumes.
    assign unused_jdo = ^jdo;

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mon_d   = mon_q;
        wdata_d = wdata_q;
        ready_d = ready_q;
        inc_d   = inc_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        err_set = 1'b0;
        // The clear applies even when the strobe itself is rejected as an overrun.
        err_clr = take_action_ocimem_a & jdo[JDO_ERR_CLR];

        unique case (state_q)
            StIdle: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[ADDR_LSB +: MON_AW];
                    if (take_action_ocimem_b || take_no_action_ocimem_a) begin
                        err_set = 1'b1;
                    end
                    if (jdo[JDO_RD_NOW] && debugack) begin
                        state_d = StRdIssue;
                        re_d    = 1'b1;
                        inc_d   = 1'b0;
                        ready_d = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    if (take_no_action_ocimem_a) begin
                        err_set = 1'b1;
                    end
                    if (debugack) begin
                        wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                        state_d = StWr;
                        we_d    = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    if (debugack) begin
                        state_d = StRdIssue;
                        re_d    = 1'b1;
                        inc_d   = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            StRdIssue: begin
                err_set = any_strobe;
                state_d = StRdWait;
            end
            StRdWait: begin
                err_set = any_strobe;
                mon_d   = mem_rdata;
                if (inc_q) begin
                    addr_d = addr_q + ADDR_ONE;
                end
                state_d = StIdle;
                ready_d = 1'b1;
            end
            StWr: begin
                err_set = any_strobe;
                addr_d  = addr_q + ADDR_ONE;
                state_d = StIdle;
                ready_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase

        if (err_clr) begin
            err_d = 1'b0;
        end else if (err_set) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            mon_q   <= '0;
            wdata_q <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mon_q   <= mon_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            re_q    <= re_d;
            we_q    <= we_d;
            inc_q   <= inc_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_re        = re_q;
    assign mem_we        = we_q;
    assign mem_wdata     = wdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = ready_q;
    assign monitor_error = err_q;

endmodule

// File: tb/tb_debug_slave_monitor_access.sv
// Scoreboard bench for debug_slave_monitor_access with a registered RAM model.
module tb_debug_slave_monitor_access;

    localparam int KW = 0;  // RAM write pulse
    localparam int KR = 1;  // RAM read pulse
    localparam int KD = 2;  // ready returned

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [37:0] jdo = '0;
    logic        sa = 1'b0;
    logic        sb = 1'b0;
    logic        sn = 1'b0;
    logic        debugack = 1'b0;
    logic [7:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    logic [31:0] ram [256];
    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        prev_ready = 1'b1;

    debug_slave_monitor_access dut (
        .clk                     (clk),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (sa),
        .take_action_ocimem_b    (sb),
        .take_no_action_ocimem_a (sn),
        .debugack                (debugack),
        .mem_addr                (mem_addr),
        .mem_re                  (mem_re),
        .mem_we                  (mem_we),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] addr, input logic [31:0] data,
                             input logic err);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
            e = sb_q.pop_front();
            check("event_kind", 32'(kind), 32'(e.kind));
            check("event_addr", 32'(mem_addr), 32'(e.addr));
            if (kind == KW) check("wr_data", mem_wdata, e.data);
            if (kind == KD) begin
                check("mondreg", MonDReg, e.data);
                check("done_error", 32'(monitor_error), 32'(e.err));
            end
        end
    endtask

    // Monitor: outputs are registered, so the falling edge is a stable sampling point.
    always @(negedge clk) begin
        if (mem_we) observe(KW);
        if (mem_re) observe(KR);
        if (monitor_ready && !prev_ready) observe(KD);
        prev_ready <= monitor_ready;
    end

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] a);
        logic [37:0] j;
        j = '0;
        j[35] = clr;
        j[34] = rd;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] j;
        j = '0;
        j[34:3] = d;
        return j;
    endfunction

    task automatic issue(input logic a, input logic b, input logic n, input logic [37:0] j);
        @(negedge clk);
        jdo = j;
        sa = a;
        sb = b;
        sn = n;
        @(negedge clk);
        sa = 1'b0;
        sb = 1'b0;
        sn = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int exp_cycles);
        int cycles;
        cycles = 0;
        while (!monitor_ready && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check(name, 32'(cycles), 32'(exp_cycles));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | 32'(i);

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(monitor_ready), 32'd1);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_re", 32'(mem_re), 32'd0);
        reset = 1'b0;
        debugack = 1'b1;

        // Address load without read, then a write with post-increment.
        issue(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'h10));
        check("load_addr", 32'(mem_addr), 32'h10);
        wait_ready("load_latency", 0);
        expect_ev(KW, 8'h10, 32'hDEAD_BEEF, 1'b0);
        expect_ev(KD, 8'h11, 32'd0, 1'b0);
        issue(1'b0, 1'b1, 1'b0, jdo_b(32'hDEAD_BEEF));
        wait_ready("write_latency", 1);

        // Read-now at a loaded address, no increment.
        expect_ev(KR, 8'h10, 32'd0, 1'b0);
        expect_ev(KD, 8'h10, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h10));
        wait_ready("read_latency", 2);

        // Post-incrementing read wraps the top address.
        issue(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'hFF));
        expect_ev(KR, 8'hFF, 32'd0, 1'b0);
        expect_ev(KD, 8'h00, 32'hA500_00FF, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 38'd0);
        wait_ready("wrap_latency", 2);

        // Write refused without debugack, then error cleared.
        debugack = 1'b0;
        issue(1'b0, 1'b1, 1'b0, jdo_b(32'h1234_5678));
        check("nodbg_error", 32'(monitor_error), 32'd1);
        check("nodbg_addr", 32'(mem_addr), 32'h00);
        check("nodbg_ready", 32'(monitor_ready), 32'd1);
        issue(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h20));
        check("clr_error", 32'(monitor_error), 32'd0);
        check("clr_addr", 32'(mem_addr), 32'h20);
        debugack = 1'b1;

        // Overrun: write strobe while the read is in flight.
        expect_ev(KR, 8'h20, 32'd0, 1'b0);
        expect_ev(KD, 8'h21, 32'hA500_0020, 1'b1);
        @(negedge clk);
        sn = 1'b1;
        @(negedge clk);
        sn = 1'b0;
        jdo = jdo_b(32'hCAFE_F00D);
        sb = 1'b1;
        @(negedge clk);
        sb = 1'b0;
        wait_ready("overrun_latency", 1);
        check("overrun_ram", ram[8'h21], 32'hA500_0021);

        // Reset while waiting on read data.
        expect_ev(KR, 8'h21, 32'd0, 1'b0);
        expect_ev(KD, 8'h00, 32'd0, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 38'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_mondreg", MonDReg, 32'd0);
        check("midrst_ready", 32'(monitor_ready), 32'd1);
        check("midrst_re", 32'(mem_re), 32'd0);
        check("midrst_error", 32'(monitor_error), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        expect_ev(KR, 8'h00, 32'd0, 1'b0);
        expect_ev(KD, 8'h01, 32'hA500_0000, 1'b0);
        issue(1'b0, 1'b0, 1'b1, 38'd0);
        wait_ready("postrst_latency", 2);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
